exu_oitf: RTL and testbench

Outstanding Instruction Track FIFO for the EXU. Records every long-pipe instruction (load/store, mul/div) that `exu_disp` dispatches, in program order, until its write-back retires it. Provides dispatch with RAW/WAW hazard flags, the allocation tag (itag), a full indication and an empty indication. Sits beside dispatch, between it and the long-pipe write-back arbiter.

---
 rtl/exu_oitf_pkg.sv | 19 +
 rtl/exu_oitf_ptr.sv | 42 ++++
 rtl/exu_oitf.sv | 105 ++++++++++
 tb/tb_exu_oitf.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/exu_oitf_pkg.sv
// rtl/exu_oitf_pkg.sv - shared widths and entry type for the outstanding instruction track FIFO
package exu_oitf_pkg;

  localparam int OITF_DEPTH  = 4;
  localparam int ITAG_WIDTH  = 2;
  localparam int RFIDX_WIDTH = 5;

  typedef struct packed {
    logic                   valid;
    logic                   rdwen;
    logic [RFIDX_WIDTH-1:0] rdidx;
  } oitf_entry_t;

  // An entry can only create a hazard if it really writes a non-zero register.
  function automatic logic entry_writes(input oitf_entry_t e);
    return e.valid && e.rdwen && (e.rdidx != '0);
  endfunction

endpackage

// File: rtl/exu_oitf_ptr.sv
// rtl/exu_oitf_ptr.sv - circular index counter with wrap flag
module exu_oitf_ptr #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] idx,
  output logic         flag
);

  logic [W-1:0] idx_q, idx_d;
  logic         flag_q, flag_d;

  always_comb begin
    idx_d  = idx_q;
    flag_d = flag_q;
    if (inc) begin
      if (idx_q == W'(DEPTH - 1)) begin
        idx_d  = '0;
        flag_d = ~flag_q;
      end else begin
        idx_d = idx_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      flag_q <= flag_d;
    end
  end

  assign idx  = idx_q;
  assign flag = flag_q;

endmodule

// File: rtl/exu_oitf.sv
// rtl/exu_oitf.sv - outstanding instruction track FIFO for long-pipe instructions
module exu_oitf
  import exu_oitf_pkg::*;
#(
  parameter int OITF_DEPTH = exu_oitf_pkg::OITF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dis_ena,
  output logic                   dis_ready,
  output logic [ITAG_WIDTH-1:0]  dis_ptr,
  input  logic                   disp_rs1en,
  input  logic                   disp_rs2en,
  input  logic                   disp_rdwen,
  input  logic [RFIDX_WIDTH-1:0] disp_rs1idx,
  input  logic [RFIDX_WIDTH-1:0] disp_rs2idx,
  input  logic [RFIDX_WIDTH-1:0] disp_rdidx,
  output logic                   oitfrd_match_disprs1,
  output logic                   oitfrd_match_disprs2,
  output logic                   oitfrd_match_disprd,
  input  logic                   ret_ena,
  output logic [ITAG_WIDTH-1:0]  ret_ptr,
  output logic                   ret_rdwen,
  output logic [RFIDX_WIDTH-1:0] ret_rdidx,
  output logic                   oitf_empty
);

  logic [ITAG_WIDTH-1:0] alloc_idx, ret_idx;
  logic                  alloc_flag, ret_flag;
  logic                  full, empty, alloc_fire, ret_fire;

  oitf_entry_t entry_q [OITF_DEPTH];
  oitf_entry_t entry_d [OITF_DEPTH];

  // Status depends only on pointer registers so dis_ready never sees dis_ena.
  assign empty      = (alloc_idx == ret_idx) && (alloc_flag == ret_flag);
  assign full       = (alloc_idx == ret_idx) && (alloc_flag != ret_flag);
  assign alloc_fire = dis_ena && !full;
  assign ret_fire   = ret_ena && !empty;

  exu_oitf_ptr #(.DEPTH(OITF_DEPTH), .W(ITAG_WIDTH)) u_alloc_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (alloc_fire),
    .idx   (alloc_idx),
    .flag  (alloc_flag)
  );

  exu_oitf_ptr #(.DEPTH(OITF_DEPTH), .W(ITAG_WIDTH)) u_ret_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ret_fire),
    .idx   (ret_idx),
    .flag  (ret_flag)
  );

  // Alloc and retire never target the same slot: that needs empty or full,
  // and each of those blocks one side.
  always_comb begin
    for (int i = 0; i < OITF_DEPTH; i++) begin
      entry_d[i] = entry_q[i];
    end
    if (ret_fire) begin
      entry_d[ret_idx].valid = 1'b0;
    end
    if (alloc_fire) begin
      entry_d[alloc_idx].valid = 1'b1;
      entry_d[alloc_idx].rdwen = disp_rdwen;
      entry_d[alloc_idx].rdidx = disp_rdidx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OITF_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < OITF_DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  always_comb begin
    oitfrd_match_disprs1 = 1'b0;
    oitfrd_match_disprs2 = 1'b0;
    oitfrd_match_disprd  = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      if (entry_writes(entry_q[i])) begin
        if (disp_rs1en && (disp_rs1idx == entry_q[i].rdidx)) oitfrd_match_disprs1 = 1'b1;
        if (disp_rs2en && (disp_rs2idx == entry_q[i].rdidx)) oitfrd_match_disprs2 = 1'b1;
        if (disp_rdwen && (disp_rdidx  == entry_q[i].rdidx)) oitfrd_match_disprd  = 1'b1;
      end
    end
  end

  assign dis_ready  = !full;
  assign oitf_empty = empty;
  assign dis_ptr    = alloc_idx;
  assign ret_ptr    = ret_idx;
  assign ret_rdwen  = entry_q[ret_idx].rdwen;
  assign ret_rdidx  = entry_q[ret_idx].rdidx;

endmodule

// File: tb/tb_exu_oitf.sv
// tb/tb_exu_oitf.sv - self-checking bench for exu_oitf against a queue reference model
module tb_exu_oitf;
  import exu_oitf_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dis_ena = 1'b0, ret_ena = 1'b0;
  logic disp_rs1en = 1'b0, disp_rs2en = 1'b0, disp_rdwen = 1'b0;
  logic [RFIDX_WIDTH-1:0] disp_rs1idx = '0, disp_rs2idx = '0, disp_rdidx = '0;
  logic dis_ready, oitf_empty, ret_rdwen;
  logic m_rs1, m_rs2, m_rd;
  logic [ITAG_WIDTH-1:0] dis_ptr, ret_ptr;
  logic [RFIDX_WIDTH-1:0] ret_rdidx;

  always #5 clk = ~clk;

  exu_oitf #(.OITF_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_ptr(dis_ptr),
    .disp_rs1en(disp_rs1en), .disp_rs2en(disp_rs2en), .disp_rdwen(disp_rdwen),
    .disp_rs1idx(disp_rs1idx), .disp_rs2idx(disp_rs2idx), .disp_rdidx(disp_rdidx),
    .oitfrd_match_disprs1(m_rs1), .oitfrd_match_disprs2(m_rs2), .oitfrd_match_disprd(m_rd),
    .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdwen(ret_rdwen), .ret_rdidx(ret_rdidx),
    .oitf_empty(oitf_empty)
  );

  typedef struct {
    logic       rdwen;
    logic [4:0] rdidx;
  } ment_t;

  ment_t q[$];
  int alloc_cnt = 0, ret_cnt = 0;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic hit(input logic en, input logic [4:0] idx);
    logic h = 1'b0;
    foreach (q[i]) if (en && q[i].rdwen && q[i].rdidx != 0 && q[i].rdidx == idx) h = 1'b1;
    return h;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".dis_ready"}, 32'(dis_ready), 32'(q.size() < 4));
    chk({tag, ".empty"}, 32'(oitf_empty), 32'(q.size() == 0));
    chk({tag, ".dis_ptr"}, 32'(dis_ptr), 32'(alloc_cnt % 4));
    chk({tag, ".ret_ptr"}, 32'(ret_ptr), 32'(ret_cnt % 4));
    chk({tag, ".m_rs1"}, 32'(m_rs1), 32'(hit(disp_rs1en, disp_rs1idx)));
    chk({tag, ".m_rs2"}, 32'(m_rs2), 32'(hit(disp_rs2en, disp_rs2idx)));
    chk({tag, ".m_rd"}, 32'(m_rd), 32'(hit(disp_rdwen, disp_rdidx)));
    if (q.size() != 0) begin
      chk({tag, ".ret_rdwen"}, 32'(ret_rdwen), 32'(q[0].rdwen));
      chk({tag, ".ret_rdidx"}, 32'(ret_rdidx), 32'(q[0].rdidx));
    end
  endtask

  task automatic cyc(input string tag, input logic de, input logic re,
                     input logic r1en, input logic [4:0] r1,
                     input logic r2en, input logic [4:0] r2,
                     input logic wen, input logic [4:0] rd);
    int sz;
    @(negedge clk);
    dis_ena = de; ret_ena = re;
    disp_rs1en = r1en; disp_rs1idx = r1;
    disp_rs2en = r2en; disp_rs2idx = r2;
    disp_rdwen = wen;  disp_rdidx = rd;
    #1;
    check_all(tag);
    @(posedge clk);
    sz = q.size();
    if (re && sz != 0) begin
      void'(q.pop_front());
      ret_cnt++;
    end
    if (de && sz != 4) begin
      q.push_back('{rdwen: wen, rdidx: rd});
      alloc_cnt++;
    end
  endtask

  task automatic model_reset();
    q.delete();
    alloc_cnt = 0;
    ret_cnt = 0;
  endtask

  initial begin
    // 1: reset
    #1;
    check_all("reset");
    chk("reset.ret_rdwen", 32'(ret_rdwen), 32'd0);
    chk("reset.ret_rdidx", 32'(ret_rdidx), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // 2: fill, then an ignored fifth allocation
    cyc("fill0", 1, 0, 0, 0, 0, 0, 1, 5);
    cyc("fill1", 1, 0, 0, 0, 0, 0, 1, 6);
    cyc("fill2", 1, 0, 0, 0, 0, 0, 1, 7);
    cyc("fill3", 1, 0, 0, 0, 0, 0, 1, 8);
    cyc("fill4", 1, 0, 0, 0, 0, 0, 1, 9);
    chk("full.dis_ready", 32'(dis_ready), 32'd0);
    chk("full.dis_ptr", 32'(dis_ptr), 32'd0);

    // 3: hazards against x5..x8
    cyc("haz_rs1", 0, 0, 1, 5, 0, 0, 0, 0);
    chk("haz_rs1.direct", 32'(m_rs1), 32'd1);
    cyc("haz_rs2_off", 0, 0, 0, 0, 0, 5, 0, 0);
    chk("haz_rs2_off.direct", 32'(m_rs2), 32'd0);
    cyc("haz_rd", 0, 0, 0, 0, 0, 0, 1, 5);
    chk("haz_rd.direct", 32'(m_rd), 32'd1);
    cyc("haz_miss", 0, 0, 1, 9, 1, 3, 1, 12);

    // 4: retire order
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("ret%0d", i), 0, 1, 1, 5'(5 + i), 0, 0, 0, 0);
    end
    cyc("drained", 0, 1, 0, 0, 0, 0, 0, 0);
    chk("drained.empty", 32'(oitf_empty), 32'd1);

    // 3b: x0 destination never matches
    cyc("x0_alloc", 1, 0, 0, 0, 0, 0, 1, 0);
    cyc("x0_probe", 0, 0, 1, 0, 1, 0, 1, 0);
    chk("x0_probe.direct", 32'(m_rs1), 32'd0);
    cyc("x0_ret", 0, 1, 0, 0, 0, 0, 0, 0);

    // 5: simultaneous alloc+retire when full and when partly filled
    for (int i = 0; i < 4; i++) cyc("refill", 1, 0, 0, 0, 0, 0, 1, 5'(10 + i));
    cyc("full_both", 1, 1, 1, 10, 0, 0, 1, 20);
    cyc("after_full_both", 0, 0, 1, 20, 1, 11, 0, 0);
    chk("after_full_both.dis_ready", 32'(dis_ready), 32'd1);
    cyc("to_two", 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("two_both", 1, 1, 0, 0, 0, 0, 1, 21);
    chk("two_both.occupancy", 32'(q.size()), 32'd2);
    cyc("two_after", 0, 0, 1, 21, 1, 13, 1, 12);

    // 5: randomized mixed operations across wraps
    for (int i = 0; i < 300; i++) begin
      cyc("rand", 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
          1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)));
    end

    // 6: reset with three entries outstanding
    while (q.size() != 0) cyc("pre_rst_drain", 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("pre_rst", 1, 0, 0, 0, 0, 0, 1, 5'(3 + i));
    @(negedge clk);
    disp_rs1en = 1; disp_rs1idx = 3; disp_rs2en = 1; disp_rs2idx = 4;
    disp_rdwen = 1; disp_rdidx = 5; dis_ena = 0; ret_ena = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.ret_rdwen", 32'(ret_rdwen), 32'd0);
    chk("async_rst.ret_rdidx", 32'(ret_rdidx), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    cyc("post_rst", 0, 0, 1, 3, 1, 4, 1, 5);
    chk("post_rst.m_rs1", 32'(m_rs1), 32'd0);
    cyc("post_rst_alloc", 1, 0, 0, 0, 0, 0, 1, 7);
    cyc("post_rst_probe", 0, 0, 1, 7, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
